regfile_write_scheduler: RTL
============================

// Module: regfile_write_scheduler
// PURPOSE
//  Shares the single write port of the 32x32 register file between NUM_REQ requesters
//  (e.g. ALU writeback, load unit, CSR/mul units) using a round-robin arbiter with
//  valid/ready handshakes.
//  Also runs a sequenced clear sweep that zeroes every register one per cycle, as a
//  software-triggered alternative to a global reset.
//  Sits directly in front of the register file: its rf_* outputs drive writeEn,
//  address_wr and write_data.
// PARAMETERS
//  NUM_REQ     4   number of write requesters (2..8)
//  DATA_WIDTH  32  write data width
//  ADDR_WIDTH  5   register address width
//  NUM_REGS    32  registers covered by a clear sweep (<= 2**ADDR_WIDTH)
//  PROTECT_R0  1   1: requester writes to address 0 are handshaken but rf_writeEn stays low
// PORTS
//  clock          in   1                   clock; all state changes on rising edge
//  reset          in   1                   asynchronous, active-high reset
//  req_valid      in   NUM_REQ             per-requester write request
//  req_ready      out  NUM_REQ             per-requester grant; at most one bit high
//  req_addr       in   NUM_REQ*ADDR_WIDTH  requester i address = [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_data       in   NUM_REQ*DATA_WIDTH  requester i data = [i*DATA_WIDTH +: DATA_WIDTH]
//  clear_start    in   1                   start clear sweep (sampled in IDLE only)
//  clear_busy     out  1                   high while in CLEAR state
//  clear_done     out  1                   one-cycle pulse when the sweep completes
//  rf_writeEn     out  1                   register-file write enable (registered)
//  rf_address_wr  out  ADDR_WIDTH          register-file write address (registered)
//  rf_write_data  out  DATA_WIDTH          register-file write data (registered)
//  grant_id       out  clog2(NUM_REQ)      index of requester that produced the current rf write
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE, rr_ptr=0, sweep counter=0.
//   - All outputs 0: req_ready, clear_busy, clear_done, rf_*, grant_id.
//   - Reset during CLEAR aborts the sweep; no clear_done is produced.
//  States:
//   - IDLE -> CLEAR on a clock edge with clear_start=1.
//   - CLEAR -> IDLE on the edge that issues address NUM_REGS-1.
//  IDLE arbitration (combinational req_ready):
//   - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
//   - The first valid requester gets req_ready=1; all other ready bits are 0.
//   - A handshake occurs when req_valid[i] & req_ready[i] is high at a rising edge.
//   - On a handshake to requester i: rr_ptr <= (i+1) mod NUM_REQ.
//   - No handshake: rr_ptr is unchanged.
//   - If clear_start=1 in IDLE: all req_ready=0 that cycle (clear wins over requests).
//  Write latency:
//   - A handshake at edge T makes rf_writeEn=1, rf_address_wr, rf_write_data and grant_id
//     valid in the cycle after T, for exactly one cycle.
//   - rf_writeEn=0 in every cycle without a new write.
//   - PROTECT_R0=1 and addr==0: handshake completes and rr_ptr advances, but rf_writeEn=0.
//  CLEAR:
//   - All req_ready=0; clear_busy=1; clear_start is ignored.
//   - Each edge issues rf_writeEn=1, rf_address_wr=cnt, rf_write_data=0, then cnt++.
//   - Addresses 0..NUM_REGS-1 are issued in order.
//   - Address 0 is written by the sweep regardless of PROTECT_R0.
//   - clear_done=1 in the same cycle the address NUM_REGS-1 write is visible.
//   - clear_busy=0 from that cycle onward; counter resets to 0.
//   - Sweep length is NUM_REGS+1 cycles from clear_start to clear_done.
//  Pending requests: requesters keep valid and data stable until handshaken.
//   The scheduler never drops or duplicates a write.
// TESTING
//  1. Reset, then req_valid=4'b0001, addr=3, data=32'hDEAD_BEEF
//     -> ready[0]=1 the same cycle; next cycle rf_writeEn=1, addr=3, data=DEADBEEF, grant_id=0.
//  2. req_valid=4'b1111 held for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, one per cycle.
//  3. PROTECT_R0=1, requester 2 writes addr 0
//     -> ready[2]=1 and ptr advances to 3; rf_writeEn stays 0.
//  4. clear_start pulse with req_valid=4'b0010 -> ready all 0 for 33 cycles;
//     rf writes addr 0..31 with data 0; clear_done pulses once with the addr-31 write;
//     ready[1]=1 the following cycle.
//  5. Async reset asserted at sweep address 10 -> all outputs 0 immediately, no clear_done;
//     next clear_start restarts the sweep at address 0.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Round-robin write-port scheduler for the register file, with a one-register-per-cycle
// clear sweep that zeroes the whole file on request.
module regfile_write_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned PROTECT_R0 = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic                            clear_start,
  output logic                            clear_busy,
  output logic                            clear_done,
  output logic                            rf_writeEn,
  output logic [ADDR_WIDTH-1:0]           rf_address_wr,
  output logic [DATA_WIDTH-1:0]           rf_write_data,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]            state_q,         state_d;
  logic [ID_W-1:0]       rr_ptr_q,        rr_ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q,           cnt_d;
  logic                  clear_busy_q,    clear_busy_d;
  logic                  clear_done_q,    clear_done_d;
  logic                  rf_writeEn_q,    rf_writeEn_d;
  logic [ADDR_WIDTH-1:0] rf_address_wr_q, rf_address_wr_d;
  logic [DATA_WIDTH-1:0] rf_write_data_q, rf_write_data_d;
  logic [ID_W-1:0]       grant_id_q,      grant_id_d;

  logic                  found;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W:0]         probe;
  logic                  grant_ok;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Rotating priority search: first valid requester at or after rr_ptr wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    probe     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      probe = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (probe >= (ID_W+1)'(NUM_REQ)) begin
        probe = probe - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[probe[ID_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = probe[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A pending clear_start blocks every grant in that cycle.
  assign grant_ok = (state_q == ST_IDLE) && !clear_start && found;

  always_comb begin
    req_ready = '0;
    if (grant_ok && !reset) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    clear_busy_d    = 1'b0;
    clear_done_d    = 1'b0;
    rf_writeEn_d    = 1'b0;
    rf_address_wr_d = rf_address_wr_q;
    rf_write_data_d = rf_write_data_q;
    grant_id_d      = grant_id_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d      = ST_CLEAR;
          cnt_d        = '0;
          clear_busy_d = 1'b1;
        end else if (found) begin
          rr_ptr_d        = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
          rf_writeEn_d    = !((PROTECT_R0 != 0) && (sel_addr == '0));
          rf_address_wr_d = sel_addr;
          rf_write_data_d = sel_data;
          grant_id_d      = grant_idx;
        end
      end
      ST_CLEAR: begin
        rf_writeEn_d    = 1'b1;
        rf_address_wr_d = cnt_q;
        rf_write_data_d = '0;
        grant_id_d      = '0;
        if (cnt_q == ADDR_WIDTH'(NUM_REGS-1)) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d        = cnt_q + ADDR_WIDTH'(1);
          clear_busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      rr_ptr_q        <= '0;
      cnt_q           <= '0;
      clear_busy_q    <= 1'b0;
      clear_done_q    <= 1'b0;
      rf_writeEn_q    <= 1'b0;
      rf_address_wr_q <= '0;
      rf_write_data_q <= '0;
      grant_id_q      <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      clear_busy_q    <= clear_busy_d;
      clear_done_q    <= clear_done_d;
      rf_writeEn_q    <= rf_writeEn_d;
      rf_address_wr_q <= rf_address_wr_d;
      rf_write_data_q <= rf_write_data_d;
      grant_id_q      <= grant_id_d;
    end
  end

  assign clear_busy    = clear_busy_q;
  assign clear_done    = clear_done_q;
  assign rf_writeEn    = rf_writeEn_q;
  assign rf_address_wr = rf_address_wr_q;
  assign rf_write_data = rf_write_data_q;
  assign grant_id      = grant_id_q;

endmodule
